uart_reg_bridge: RTL and testbench
==================================

# uart_reg_bridge

- Command responder on the far side of the AXI4-Stream UART: parses byte commands from the UART receive stream and executes them on a simple register bus.
- Returns response bytes on the UART transmit stream.
- Connects between uart_rx (m_axis) / uart_tx (s_axis) and on-chip control/status registers, so a host terminal can read and write registers over a serial link.

## Interface
Parameters:
- ADDR_WIDTH, 8: register address width; fixed at one command byte.
- TIMEOUT, 255: bus cycles to wait for reg_ack before abandoning; 1..65535.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_axis_tdata  in  8  command byte from uart_rx
- s_axis_tvalid  in  1  command byte valid
- s_axis_tready  out  1  bridge accepts command byte
- m_axis_tdata  out  8  response byte to uart_tx
- m_axis_tvalid  out  1  response byte valid
- m_axis_tready  in  1  uart_tx accepts response byte
- reg_addr  out  8  register address
- reg_wdata  out  16  write data
- reg_wr  out  1  write request, held until ack or timeout
- reg_rd  out  1  read request, held until ack or timeout
- reg_rdata  in  16  read data, sampled in the cycle reg_ack=1 during a read
- reg_ack  in  1  bus completion
- busy  out  1  high in every state except IDLE
- cmd_error  out  1  one-cycle pulse on any error response

## Operation
Command frames (multi-byte fields MSB first):
- Write: 0x57 'W', addr, d_hi, d_lo. Response: 0x4B 'K'.
- Read: 0x52 'R', addr. Response: 0x44 'D', d_hi, d_lo.
- Other opcode byte: response 0x45 'E'; no further bytes consumed for that frame.
- Bus timeout: response 0x54 'T'.

FSM states and transitions:
- IDLE: tready=1 → GET_ADDR on 'W'/'R'; → SEND('E') on anything else.
- GET_ADDR: tready=1 → GET_DH (write) or BUS (read).
- GET_DH, GET_DL: tready=1 → GET_DL, then BUS.
- GET_CSUM: only with the macro; see Configuration.
- BUS: assert reg_wr or reg_rd with reg_addr/reg_wdata stable; tready=0.
  - reg_ack → SEND with 'K' or 'D',hi,lo.
  - Timeout counter reaches TIMEOUT → SEND with 'T'.
- SEND: tready=0; emit response bytes from a 4-byte buffer indexed by a 2-bit counter; after the last byte handshakes → IDLE.

Rules:
- A byte is consumed only on s_axis_tvalid && s_axis_tready.
- Timeout counter is 16-bit, cleared on entry to BUS, increments each BUS cycle.
- cmd_error pulses in the cycle SEND is entered with 'E' or 'T'.

Boundaries:
- reg_ack in the same cycle the counter hits TIMEOUT: ack wins.
- reg_ack outside BUS: ignored.
- rst mid-frame or mid-response: immediate return to IDLE; partial frame and pending response discarded, no bus request issued.
- m_axis_tready held low: bridge stalls in SEND indefinitely; no command bytes accepted meanwhile.

## Timing
- Reset values:
  - s_axis_tready 0; goes to 1 the first cycle after reset deasserts.
  - m_axis_tvalid 0, m_axis_tdata 0x00.
  - reg_wr 0, reg_rd 0, reg_addr 0, reg_wdata 0.
  - busy 0, cmd_error 0.
- Last command byte handshake at cycle N → reg_wr/reg_rd high at N+1.
- reg_ack sampled high at cycle M → request low at M+1; m_axis_tvalid high with the first response byte at M+1.
- Response byte handshake at cycle K → next byte valid at K+1 (back-to-back), or IDLE with tready=1 at K+1 after the last byte.
- m_axis_tdata/tvalid are registered, held stable while tvalid && !tready.
- Zero-wait bus (ack tied high): 'W' frame last byte at N → 'K' valid at N+2.

## Configuration
UART_BRIDGE_CHECKSUM_EN:
- Defined: every command frame carries one trailing byte equal to the XOR of all preceding frame bytes, received in GET_CSUM before BUS.
  - Mismatch → SEND('E'), no bus request.
  - Every response gets an appended XOR byte: 'K' → 0x4B,0x4B; 'D',hi,lo → 0x44,hi,lo,0x44^hi^lo; 'E' → 0x45,0x45; 'T' → 0x54,0x54.
- Undefined: no GET_CSUM state; frames and responses as in Operation.

## Test plan
- Write: send 0x57,0x10,0xBE,0xEF with ack one cycle after the request → reg_wr high with reg_addr=0x10, reg_wdata=0xBEEF, for exactly 2 cycles; response 0x4B.
- Read: send 0x52,0x22 with reg_rdata=0x1234 and ack after 5 cycles → response 0x44,0x12,0x34; no reg_wr activity.
- Bad opcode and timeout:
  - Send 0x41 → response 0x45, cmd_error pulses once; next 'R' frame processed normally.
  - Read with ack never asserted, TIMEOUT=8 → reg_rd high for 8 cycles, response 0x54.
- Backpressure and reset: read response with m_axis_tready toggling 1 cycle on/3 off → bytes in order, tdata stable while stalled. Assert rst after 2 bytes of a write → no reg_wr, all outputs at reset values next cycle.
- Checksum (macro defined):
  - 0x57,0x01,0x00,0x05,0x53 → write performed, response 0x4B,0x4B.
  - Same frame with last byte 0x00 → response 0x45,0x45, no reg_wr.

Source files
------------

// File: rtl/uart_reg_bridge.sv
// Byte-command bridge: parses UART command frames and runs them as register bus accesses.
// Build option UART_BRIDGE_CHECKSUM_EN adds an XOR checksum byte to every command and response.
module uart_reg_bridge #(
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [7:0]            m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [15:0]           reg_wdata,
  output logic                  reg_wr,
  output logic                  reg_rd,
  input  logic [15:0]           reg_rdata,
  input  logic                  reg_ack,
  output logic                  busy,
  output logic                  cmd_error
);

  localparam logic [7:0]  OP_W     = 8'h57;
  localparam logic [7:0]  OP_R     = 8'h52;
  localparam logic [7:0]  RSP_K    = 8'h4B;
  localparam logic [7:0]  RSP_D    = 8'h44;
  localparam logic [7:0]  RSP_E    = 8'h45;
  localparam logic [7:0]  RSP_T    = 8'h54;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_DH, GET_DL,
`ifdef UART_BRIDGE_CHECKSUM_EN
    GET_CSUM,
`endif
    BUS, SEND
  } state_t;

`ifdef UART_BRIDGE_CHECKSUM_EN
  localparam state_t FRAME_END = GET_CSUM;
  logic [7:0] csum;
`else
  localparam state_t FRAME_END = BUS;
`endif

  state_t          state, state_next;
  logic            is_wr;
  logic [15:0]     tcount;
  logic [3:0][7:0] rsp_buf, rsp_new;
  logic [1:0]      rsp_idx, rsp_last, rsp_new_last;
  logic [7:0]      rsp_code;
  logic            rsp_load;
  logic            rx_state, accept, tx_done;

  always_comb begin
    rx_state = (state == IDLE) || (state == GET_ADDR) || (state == GET_DH) || (state == GET_DL);
`ifdef UART_BRIDGE_CHECKSUM_EN
    rx_state = rx_state || (state == GET_CSUM);
`endif
  end

  // Gated by rst so nothing is offered while reset is held.
  assign s_axis_tready = rx_state && !rst;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign tx_done       = (state == SEND) && m_axis_tvalid && m_axis_tready && (rsp_idx == rsp_last);
  assign reg_wr        = (state == BUS) && is_wr;
  assign reg_rd        = (state == BUS) && !is_wr;
  assign busy          = (state != IDLE);

  always_comb begin
    state_next = state;
    rsp_load   = 1'b0;
    rsp_code   = 8'h00;
    case (state)
      IDLE: if (accept) begin
        if (s_axis_tdata == OP_W || s_axis_tdata == OP_R) state_next = GET_ADDR;
        else begin rsp_load = 1'b1; rsp_code = RSP_E; end
      end
      GET_ADDR: if (accept) state_next = is_wr ? GET_DH : FRAME_END;
      GET_DH:   if (accept) state_next = GET_DL;
      GET_DL:   if (accept) state_next = FRAME_END;
`ifdef UART_BRIDGE_CHECKSUM_EN
      GET_CSUM: if (accept) begin
        if (s_axis_tdata == csum) state_next = BUS;
        else begin rsp_load = 1'b1; rsp_code = RSP_E; end
      end
`endif
      BUS: begin
        // Ack has priority over a timeout landing in the same cycle.
        if (reg_ack) begin
          rsp_load = 1'b1;
          rsp_code = is_wr ? RSP_K : RSP_D;
        end else if (tcount == TMO_LAST) begin
          rsp_load = 1'b1;
          rsp_code = RSP_T;
        end
      end
      SEND: if (tx_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (rsp_load) state_next = SEND;
  end

  always_comb begin
    rsp_new      = '0;
    rsp_new_last = 2'd0;
    rsp_new[0]   = rsp_code;
    if (rsp_code == RSP_D) begin
      rsp_new[1]   = reg_rdata[15:8];
      rsp_new[2]   = reg_rdata[7:0];
      rsp_new_last = 2'd2;
`ifdef UART_BRIDGE_CHECKSUM_EN
      rsp_new[3]   = rsp_code ^ reg_rdata[15:8] ^ reg_rdata[7:0];
      rsp_new_last = 2'd3;
`endif
    end else begin
`ifdef UART_BRIDGE_CHECKSUM_EN
      rsp_new[1]   = rsp_code;
      rsp_new_last = 2'd1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      is_wr         <= 1'b0;
      reg_addr      <= '0;
      reg_wdata     <= '0;
      tcount        <= '0;
      rsp_buf       <= '0;
      rsp_idx       <= '0;
      rsp_last      <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      cmd_error     <= 1'b0;
`ifdef UART_BRIDGE_CHECKSUM_EN
      csum          <= '0;
`endif
    end else begin
      state     <= state_next;
      cmd_error <= rsp_load && (rsp_code == RSP_E || rsp_code == RSP_T);
      tcount    <= (state == BUS) ? tcount + 16'd1 : 16'd0;
      if (accept) begin
        case (state)
          IDLE:     is_wr <= (s_axis_tdata == OP_W);
          GET_ADDR: reg_addr <= s_axis_tdata[ADDR_WIDTH-1:0];
          GET_DH:   reg_wdata[15:8] <= s_axis_tdata;
          GET_DL:   reg_wdata[7:0] <= s_axis_tdata;
          default:  ;
        endcase
`ifdef UART_BRIDGE_CHECKSUM_EN
        csum <= (state == IDLE) ? s_axis_tdata : (csum ^ s_axis_tdata);
`endif
      end
      if (rsp_load) begin
        rsp_buf       <= rsp_new;
        rsp_last      <= rsp_new_last;
        rsp_idx       <= 2'd0;
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= rsp_new[0];
      end else if (state == SEND && m_axis_tvalid && m_axis_tready) begin
        if (rsp_idx == rsp_last) begin
          m_axis_tvalid <= 1'b0;
        end else begin
          rsp_idx      <= rsp_idx + 2'd1;
          m_axis_tdata <= rsp_buf[rsp_idx + 2'd1];
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Self-checking bench for uart_reg_bridge: scoreboarded responses plus a simple bus responder.
module tb_uart_reg_bridge;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_axis_tdata = 8'h00;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_wr, reg_rd;
  logic [15:0] reg_rdata = 16'h0000;
  logic        reg_ack = 1'b0;
  logic        busy, cmd_error;

  uart_reg_bridge #(.ADDR_WIDTH(8), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_rdata(reg_rdata), .reg_ack(reg_ack), .busy(busy), .cmd_error(cmd_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  int ack_delay = -1;
  int req_cnt = 0;
  int wr_cycles = 0, rd_cycles = 0, err_pulses = 0;
  logic [7:0]  wr_addr_seen = 8'h00;
  logic [15:0] wr_data_seen = 16'h0000;

  // Bus responder: ack after ack_delay request cycles (never if negative).
  always @(negedge clk) begin
    if (reg_wr || reg_rd) begin
      reg_ack = (ack_delay >= 0 && req_cnt == ack_delay);
      req_cnt++;
    end else begin
      reg_ack = 1'b0;
      req_cnt = 0;
    end
    if (reg_wr) begin
      wr_cycles++;
      wr_addr_seen = reg_addr;
      wr_data_seen = reg_wdata;
    end
    if (reg_rd) rd_cycles++;
    if (cmd_error) err_pulses++;
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 200) begin
      n_fail++;
      $display("FAIL send_byte: tready stuck at %b, required 1 for byte %h", s_axis_tready, b);
    end
    @(posedge clk);
    #1 s_axis_tvalid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] f[5], input int n, input bit with_csum);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < n; i++) begin
      send_byte(f[i]);
      x ^= f[i];
    end
`ifdef UART_BRIDGE_CHECKSUM_EN
    if (with_csum) send_byte(x);
`endif
  endtask

  task automatic push_rsp(input logic [7:0] code, input logic [15:0] d);
    exp_q.push_back(code);
    if (code == 8'h44) begin
      exp_q.push_back(d[15:8]);
      exp_q.push_back(d[7:0]);
    end
`ifdef UART_BRIDGE_CHECKSUM_EN
    exp_q.push_back(code == 8'h44 ? (code ^ d[15:8] ^ d[7:0]) : code);
`endif
  endtask

  // Drains the scoreboard; toggle gives tready 1 cycle on, 3 off.
  task automatic wait_rsp(input bit toggle);
    int c = 0;
    logic [7:0] e;
    while (exp_q.size() > 0 && c < 400) begin
      @(negedge clk);
      m_axis_tready = toggle ? (c % 4 == 0) : 1'b1;
      if (m_axis_tvalid && m_axis_tready) begin
        e = exp_q.pop_front();
        n_checks++;
        if (m_axis_tdata !== e) begin
          n_fail++;
          $display("FAIL rsp_byte: got %h, required %h", m_axis_tdata, e);
        end
      end else if (m_axis_tvalid && toggle) begin
        n_checks++;
        if (m_axis_tdata !== exp_q[0] || s_axis_tready !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_hold: tdata %h tready %b, required %h and 0", m_axis_tdata, s_axis_tready, exp_q[0]);
        end
      end
      c++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rsp_timeout: %0d bytes outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1 m_axis_tready = 1'b0;
  endtask

  task automatic check_idle_outputs(input string name, input logic exp_tready);
    n_checks++;
    if (s_axis_tready !== exp_tready || m_axis_tvalid !== 1'b0 || m_axis_tdata !== 8'h00 ||
        reg_wr !== 1'b0 || reg_rd !== 1'b0 || reg_addr !== 8'h00 || reg_wdata !== 16'h0000 ||
        busy !== 1'b0 || cmd_error !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: tready %b tvalid %b tdata %h wr %b rd %b addr %h wdata %h busy %b err %b, required reset values",
               name, s_axis_tready, m_axis_tvalid, m_axis_tdata, reg_wr, reg_rd, reg_addr, reg_wdata, busy, cmd_error);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset_values", 1'b0);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (s_axis_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL tready_after_reset: got %b, required 1", s_axis_tready);
    end
  endtask

  task automatic test_write();
    int w0 = wr_cycles, r0 = rd_cycles;
    ack_delay = 1;
    send_frame('{8'h57, 8'h10, 8'hBE, 8'hEF, 8'h00}, 4, 1'b1);
    n_checks++;
    if (reg_wr !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_latency: reg_wr %b one cycle after last byte, required 1", reg_wr);
    end
    push_rsp(8'h4B, 16'h0000);
    wait_rsp(1'b0);
    n_checks++;
    if (wr_cycles - w0 != 2 || rd_cycles != r0) begin
      n_fail++;
      $display("FAIL wr_cycles: wr %0d rd %0d, required 2 and 0", wr_cycles - w0, rd_cycles - r0);
    end
    n_checks++;
    if (wr_addr_seen !== 8'h10 || wr_data_seen !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL wr_fields: addr %h data %h, required 10 and beef", wr_addr_seen, wr_data_seen);
    end
  endtask

  task automatic test_read();
    int w0 = wr_cycles, r0 = rd_cycles;
    ack_delay = 5;
    reg_rdata = 16'h1234;
    send_frame('{8'h52, 8'h22, 8'h00, 8'h00, 8'h00}, 2, 1'b1);
    push_rsp(8'h44, 16'h1234);
    wait_rsp(1'b0);
    n_checks++;
    if (rd_cycles - r0 != 6 || wr_cycles != w0) begin
      n_fail++;
      $display("FAIL rd_cycles: rd %0d wr %0d, required 6 and 0", rd_cycles - r0, wr_cycles - w0);
    end
  endtask

  task automatic test_bad_opcode();
    int e0 = err_pulses;
    send_frame('{8'h41, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 1'b0);
    push_rsp(8'h45, 16'h0000);
    wait_rsp(1'b0);
    n_checks++;
    if (err_pulses - e0 != 1) begin
      n_fail++;
      $display("FAIL err_pulse: got %0d pulses, required 1", err_pulses - e0);
    end
    ack_delay = 2;
    reg_rdata = 16'h0F0F;
    send_frame('{8'h52, 8'h07, 8'h00, 8'h00, 8'h00}, 2, 1'b1);
    push_rsp(8'h44, 16'h0F0F);
    wait_rsp(1'b0);
  endtask

  task automatic test_timeout();
    int r0 = rd_cycles, e0 = err_pulses;
    ack_delay = -1;
    send_frame('{8'h52, 8'h33, 8'h00, 8'h00, 8'h00}, 2, 1'b1);
    push_rsp(8'h54, 16'h0000);
    wait_rsp(1'b0);
    n_checks++;
    if (rd_cycles - r0 != 8 || err_pulses - e0 != 1) begin
      n_fail++;
      $display("FAIL timeout: rd %0d err %0d, required 8 and 1", rd_cycles - r0, err_pulses - e0);
    end
  endtask

  task automatic test_back_to_back();
    ack_delay = 0;
    reg_rdata = 16'hA55A;
    send_frame('{8'h52, 8'h44, 8'h00, 8'h00, 8'h00}, 2, 1'b1);
    push_rsp(8'h44, 16'hA55A);
    wait_rsp(1'b1);
  endtask

  task automatic test_reset_mid_frame();
    int w0;
    send_byte(8'h57);
    send_byte(8'h05);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 check_idle_outputs("reset_mid_frame", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    w0 = wr_cycles;
    repeat (10) @(negedge clk);
    n_checks++;
    if (wr_cycles != w0 || busy !== 1'b0 || s_axis_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset: wr %0d busy %b tready %b, required 0, 0, 1", wr_cycles - w0, busy, s_axis_tready);
    end
  endtask

`ifdef UART_BRIDGE_CHECKSUM_EN
  task automatic test_checksum();
    int w0 = wr_cycles;
    ack_delay = 1;
    send_frame('{8'h57, 8'h01, 8'h00, 8'h05, 8'h53}, 5, 1'b0);
    push_rsp(8'h4B, 16'h0000);
    wait_rsp(1'b0);
    n_checks++;
    if (wr_cycles - w0 != 2 || wr_addr_seen !== 8'h01 || wr_data_seen !== 16'h0005) begin
      n_fail++;
      $display("FAIL csum_good: wr %0d addr %h data %h, required 2, 01, 0005", wr_cycles - w0, wr_addr_seen, wr_data_seen);
    end
    w0 = wr_cycles;
    send_frame('{8'h57, 8'h01, 8'h00, 8'h05, 8'h00}, 5, 1'b0);
    push_rsp(8'h45, 16'h0000);
    wait_rsp(1'b0);
    n_checks++;
    if (wr_cycles != w0) begin
      n_fail++;
      $display("FAIL csum_bad: wr %0d cycles, required 0", wr_cycles - w0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_opcode();
    test_timeout();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_BRIDGE_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
